// File: rtl/uart_word_receiver_if.sv
// ----------------------------------------------------------------------------
// uart_word_receiver_if
//   Valid/ready stream carrying packed words out of uart_word_receiver.
//
//   Parameter:
//     WORD_BYTES : bytes per word (must match the receiver instance)
//
//   Signals:
//     m_data  : head-of-FIFO word, byte 0 in bits [7:0]
//     m_last  : head word ended a null-terminated string
//     m_valid : head word valid
//     m_ready : consumer accepts head word when m_valid && m_ready
//
//   Modports:
//     master : producer side (the receiver)
//     slave  : consumer side
// ----------------------------------------------------------------------------
interface uart_word_receiver_if #(
    parameter int WORD_BYTES = 4
);
    logic [8*WORD_BYTES-1:0] m_data;
    logic                    m_last;
    logic                    m_valid;
    logic                    m_ready;

    modport master (
        output m_data,
        output m_last,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_last,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/uart_word_receiver.sv
// ----------------------------------------------------------------------------
// uart_word_receiver
//   8N1 UART receiver that packs received bytes little-endian into words and
//   queues them in a small FIFO. A 0x00 byte terminates a string: the partial
//   word is pushed at once (upper bytes zero) and flagged with m_last.
//
//   Parameters:
//     CLOCK_FREQUENCY : system clock in Hz
//     BAUD_RATE       : UART bit rate (CLOCK_FREQUENCY/BAUD_RATE must be >= 4)
//     WORD_BYTES      : bytes per output word, 1..8
//     FIFO_DEPTH      : output FIFO entries, power of two, >= 2
//
//   Ports:
//     clock             : system clock, rising edge
//     reset             : synchronous, active-high
//     uart_receive      : asynchronous UART line, idle high
//     m_if              : word stream (master modport)
//     overflow          : sticky, a word was dropped on a full FIFO
//     frame_error_count : saturating count of bad stop bits
//
//   Build option:
//     UART_RX_FRAME_ERROR_COUNT_EN : when defined, frame_error_count counts
//                                    frame errors; otherwise it is tied to 0.
// ----------------------------------------------------------------------------
module uart_word_receiver #(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE       = 9600,
    parameter int WORD_BYTES      = 4,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 uart_receive,
    uart_word_receiver_if.master m_if,
    output logic                 overflow,
    output logic [15:0]          frame_error_count
);

    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int WORD_W       = 8 * WORD_BYTES;

    localparam logic [CNT_W-1:0] HALF_BIT   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORD_BYTES - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_e;

    // ------------------------------------------------------------------
    // Input synchronizer, reset to the idle (high) line level.
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q;
    logic rx_bit;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, which makes the two stages
    // a real two-flop chain rather than a single wire.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_receive;
            sync2_q <= sync1_q;
        end
    end

    assign rx_bit = sync2_q;

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    // NOTE: every variable written here gets a default first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err    = 1'b0;
        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!rx_bit) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                // Re-check the line mid start bit to reject glitches.
                if (clk_cnt_q == HALF_BIT) begin
                    clk_cnt_d = '0;
                    state_d   = rx_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_q == FULL_BIT) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (clk_cnt_q == FULL_BIT) begin
                    clk_cnt_d = '0;
                    if (rx_bit) begin
                        byte_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                clk_cnt_d = '0;
                if (rx_bit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Word packer. shift_q holds the accepted byte while byte_valid_q is
    // high: the next frame cannot reach DATA for at least a bit time.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] packed_word;
    logic              push;
    logic              push_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_idx_q <= '0;
            word_q     <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

    always_comb begin
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        packed_word = word_q;
        push        = 1'b0;
        push_last   = 1'b0;
        if (byte_valid_q) begin
            packed_word[{byte_idx_q, 3'b000} +: 8] = shift_q;
            if (shift_q == 8'h00 || byte_idx_q == LAST_IDX) begin
                push       = 1'b1;
                push_last  = (shift_q == 8'h00);
                word_d     = '0;
                byte_idx_d = '0;
            end else begin
                word_d     = packed_word;
                byte_idx_d = byte_idx_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] mem_data_q [FIFO_DEPTH];
    logic              mem_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              overflow_q;
    logic              fifo_valid;
    logic              pop;
    logic              full;
    logic              wr_en;

    assign fifo_valid = (count_q != '0);
    assign pop        = fifo_valid && m_if.m_ready;
    assign full       = (count_q == FULL_COUNT);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign wr_en      = push && (!full || pop);

    // NOTE: the storage array has no reset; only pointers and count do.
    // Entries are never read before being written, and leaving the array
    // unreset lets it map onto plain RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_data_q[wr_ptr_q] <= packed_word;
            mem_last_q[wr_ptr_q] <= push_last;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push && !wr_en) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Head is forced to zero while empty so reset leaves m_data at 0.
    assign m_if.m_valid = fifo_valid;
    assign m_if.m_data  = fifo_valid ? mem_data_q[rd_ptr_q] : '0;
    assign m_if.m_last  = fifo_valid ? mem_last_q[rd_ptr_q] : 1'b0;
    assign overflow     = overflow_q;

    // ------------------------------------------------------------------
    // Frame error counter
    // ------------------------------------------------------------------
`ifdef UART_RX_FRAME_ERROR_COUNT_EN
    logic [15:0] frame_error_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_error_count_q <= '0;
        end else if (frame_err && frame_error_count_q != 16'hFFFF) begin
            frame_error_count_q <= frame_error_count_q + 16'd1;
        end
    end

    assign frame_error_count = frame_error_count_q;
`else
    logic frame_err_unused;

    assign frame_err_unused  = frame_err;
    assign frame_error_count = '0;
`endif

endmodule

// File: tb/tb_uart_word_receiver.sv
// ----------------------------------------------------------------------------
// tb_uart_word_receiver
//   Self-checking bench for uart_word_receiver with CLOCK_FREQUENCY=100,
//   BAUD_RATE=10 (10 clocks per bit), WORD_BYTES=4, FIFO_DEPTH=2.
//   Inputs change and outputs are read on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_uart_word_receiver;

    localparam int CPB = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        uart_receive = 1'b1;
    logic        overflow;
    logic [15:0] frame_error_count;

    uart_word_receiver_if #(.WORD_BYTES(4)) m_if ();

    uart_word_receiver #(
        .CLOCK_FREQUENCY(100),
        .BAUD_RATE      (10),
        .WORD_BYTES     (4),
        .FIFO_DEPTH     (2)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .uart_receive     (uart_receive),
        .m_if             (m_if),
        .overflow         (overflow),
        .frame_error_count(frame_error_count)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Collector: records every word the consumer accepts.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t got[$];

    always @(negedge clock) begin
        #1;
        if (!reset && m_if.m_valid && m_if.m_ready) begin
            got.push_back({m_if.m_data, m_if.m_last});
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        uart_receive = b;
        repeat (CPB) @(negedge clock);
    endtask

    // Start bit, 8 data bits LSB first, stop bit, one idle bit time.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
        end
        send_bit(stop_bit);
        send_bit(1'b1);
    endtask

    task automatic wait_words(input int n, input string name);
        for (int c = 0; c < 3000 && got.size() < n; c++) begin
            @(negedge clock);
        end
        check(name, 64'(got.size()), 64'(n));
    endtask

    task automatic check_word(input string name, input int idx,
                              input logic [31:0] exp_data, input logic exp_last);
        if (idx < got.size()) begin
            check({name, " data"}, 64'(got[idx].data), 64'(exp_data));
            check({name, " last"}, 64'(got[idx].last), 64'(exp_last));
        end else begin
            check({name, " present"}, 64'(0), 64'(1));
        end
    endtask

    // ------------------------------------------------------------------
    // Single-word vectors: n bytes (byte k in bytes[8k+7:8k]) -> one word
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [2:0]  n;
        logic [31:0] bytes;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    vec_t vecs[6];

    int base;
    int fec_exp;

    initial begin
        vecs[0] = '{3'd4, 32'h4433_2211, 32'h4433_2211, 1'b0};
        vecs[1] = '{3'd2, 32'h0000_00AB, 32'h0000_00AB, 1'b1};
        vecs[2] = '{3'd1, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[3] = '{3'd4, 32'h0056_3412, 32'h0056_3412, 1'b1};
        vecs[4] = '{3'd4, 32'h0180_FEFF, 32'h0180_FEFF, 1'b0};
        vecs[5] = '{3'd3, 32'h0000_3C7A, 32'h0000_3C7A, 1'b1};

        m_if.m_ready = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        check("reset m_valid",  64'(m_if.m_valid), 64'(0));
        check("reset m_last",   64'(m_if.m_last), 64'(0));
        check("reset m_data",   64'(m_if.m_data), 64'(0));
        check("reset overflow", 64'(overflow), 64'(0));
        check("reset fec",      64'(frame_error_count), 64'(0));

        m_if.m_ready = 1'b1;

        // Table-driven words
        for (int i = 0; i < 6; i++) begin
            base = got.size();
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                send_byte(vecs[i].bytes[8*k +: 8], 1'b1);
            end
            wait_words(base + 1, $sformatf("vec%0d count", i));
            check_word($sformatf("vec%0d", i), base, vecs[i].exp_data, vecs[i].exp_last);
        end

        // 35-byte string: 11 22 33 44, 30x 01, 00
        base = got.size();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        for (int k = 0; k < 30; k++) begin
            send_byte(8'h01, 1'b1);
        end
        send_byte(8'h00, 1'b1);
        wait_words(base + 9, "string count");
        check_word("string w1", base, 32'h4433_2211, 1'b0);
        for (int w = 1; w < 8; w++) begin
            check_word($sformatf("string w%0d", w + 1), base + w, 32'h0101_0101, 1'b0);
        end
        check_word("string w9", base + 8, 32'h0000_0101, 1'b1);

        // Two-clock glitch must not produce a byte or disturb the packer
        base = got.size();
        uart_receive = 1'b0;
        repeat (2) @(negedge clock);
        uart_receive = 1'b1;
        repeat (4 * CPB) @(negedge clock);
        check("glitch no word", 64'(got.size()), 64'(base));
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        wait_words(base + 1, "glitch count");
        check_word("glitch word", base, 32'h0403_0201, 1'b0);

        // Frame error: 0x55 with bad stop bit is dropped
        base = got.size();
        send_byte(8'h55, 1'b0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        wait_words(base + 1, "frame err count");
        check_word("frame err word", base, 32'hDDCC_BBAA, 1'b0);
`ifdef UART_RX_FRAME_ERROR_COUNT_EN
        fec_exp = 1;
`else
        fec_exp = 0;
`endif
        check("frame err fec", 64'(frame_error_count), 64'(fec_exp));

        // Reset during DATA of byte 3 discards the partial word
        base = got.size();
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset        = 1'b1;
        uart_receive = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (5 * CPB) @(negedge clock);
        check("midreset m_valid", 64'(m_if.m_valid), 64'(0));
        check("midreset no word", 64'(got.size()), 64'(base));
        check("midreset fec", 64'(frame_error_count), 64'(0));
        send_byte(8'hC1, 1'b1);
        send_byte(8'hC2, 1'b1);
        send_byte(8'hC3, 1'b1);
        send_byte(8'hC4, 1'b1);
        wait_words(base + 1, "midreset count");
        check_word("midreset word", base, 32'hC4C3_C2C1, 1'b0);

        // Overflow: 12 words into a 2-deep FIFO with the consumer stalled
        m_if.m_ready = 1'b0;
        check("pre overflow", 64'(overflow), 64'(0));
        for (int w = 0; w < 12; w++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(8'(4 * w + k + 1), 1'b1);
            end
        end
        check("ovf m_valid",  64'(m_if.m_valid), 64'(1));
        check("ovf overflow", 64'(overflow), 64'(1));
        check("ovf head data", 64'(m_if.m_data), 64'(32'h0403_0201));
        check("ovf head last", 64'(m_if.m_last), 64'(0));
        base = got.size();
        m_if.m_ready = 1'b1;
        repeat (20) @(negedge clock);
        check("ovf drained count", 64'(got.size()), 64'(base + 2));
        check_word("ovf w1", base, 32'h0403_0201, 1'b0);
        check_word("ovf w2", base + 1, 32'h0807_0605, 1'b0);
        check("ovf empty", 64'(m_if.m_valid), 64'(0));
        check("ovf sticky", 64'(overflow), 64'(1));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_word_receiver.md
UART_WORD_RECEIVER -- requirements
Module: uart_word_receiver

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, UART bit rate; CLKS_PER_BIT = CLOCK_FREQUENCY/BAUD_RATE (integer division), legal only if >= 4.
REQ-003 SHALL have parameter WORD_BYTES, default 4, bytes packed per output word, legal range 1..8.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, output word FIFO entries, power of two, >= 2.
REQ-005 SHALL have port clock  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port uart_receive  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-008 SHALL have port m_data  output  8*WORD_BYTES  head-of-FIFO word.
REQ-009 SHALL have port m_last  output  1  head word terminated a null-terminated string.
REQ-010 SHALL have port m_valid  output  1  head word valid.
REQ-011 SHALL have port m_ready  input  1  consumer accepts head word when m_valid && m_ready.
REQ-012 SHALL have port overflow  output  1  sticky: a word was dropped because the FIFO was full.
REQ-013 SHALL have port frame_error_count  output  16  count of bad stop bits (see Configuration).

Function
REQ-014 SHALL pass uart_receive through a 2-flop synchronizer; only the synchronized value is used.
REQ-015 RX FSM SHALL have states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-016 IDLE -> START when synchronized line is 0; bit counter cleared.
REQ-017 START: after CLKS_PER_BIT/2 cycles, sample; 0 -> DATA, 1 -> IDLE (glitch rejected, no byte).
REQ-018 DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, then -> STOP.
REQ-019 STOP: sample after CLKS_PER_BIT cycles; 1 -> byte accepted, IDLE; 0 -> byte discarded, frame error, WAIT_IDLE.
REQ-020 WAIT_IDLE -> IDLE on first cycle line reads 1.
REQ-021 Packer SHALL place accepted byte k (k = 0..WORD_BYTES-1, arrival order) at m_data bits [8k+7:8k] (little-endian).
REQ-022 Word SHALL be pushed when byte index reaches WORD_BYTES-1, or immediately when accepted byte is 0x00; unfilled upper bytes are 0.
REQ-023 Pushed word SHALL carry last=1 iff it contains the 0x00 terminator; byte index then restarts at 0.
REQ-024 Push SHALL occur the cycle after byte acceptance; word SHALL appear on m_data with m_valid=1 the cycle after push (empty FIFO).
REQ-025 Pop SHALL occur on m_valid && m_ready; m_data/m_last change only on pop or on push into empty FIFO.
REQ-026 Full FIFO: push with simultaneous pop SHALL be accepted; push without pop SHALL drop the word and set overflow.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-028 m_ready while m_valid=0 SHALL have no effect.

Reset
REQ-029 Reset SHALL force: FSM IDLE, synchronizer flops 1, byte index 0, FIFO empty, m_valid 0, m_last 0, m_data 0, overflow 0, frame_error_count 0.
REQ-030 Reset mid-frame or mid-word SHALL discard the partial byte/word; no push results.

Configuration
REQ-031 Macro UART_RX_FRAME_ERROR_COUNT_EN defined: frame_error_count increments by 1 per REQ-019 frame error, saturating at 16'hFFFF.
REQ-032 Macro undefined: counter logic absent, frame_error_count tied to 0; all other behaviour identical.

Verification
REQ-033 CLOCK_FREQUENCY=100, BAUD_RATE=10, WORD_BYTES=4: send 11 22 33 44 -> one word 0x44332211, m_last=0.
REQ-034 Same config: send 11 22 33 44, 30x 01, 00 (35 bytes), m_ready=1 -> 9 words, words 2..8 = 0x01010101, word 9 = 0x00000101 with m_last=1.
REQ-035 FIFO_DEPTH=2, m_ready=0, send 12 full words -> m_valid=1, overflow=1, first two words intact after m_ready raised.
REQ-036 Byte 0x55 with stop bit 0, then 0xAA valid -> 0x55 absent from stream; frame_error_count=1 with macro, 0 without.
REQ-037 Low pulse on uart_receive of 2 clocks -> no byte accepted, FSM back in IDLE.
REQ-038 Reset asserted during DATA of byte 3 of a word -> m_valid stays 0; next 4 bytes form a fresh word.
